exec_stage: RTL and testbench
=============================

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 in_valid  input  1  upstream decoded instruction valid.
REQ-003 in_ready  output  1  stage can accept an instruction this cycle.
REQ-004 icode, ifun  input  4 each  Y86 instruction code and function.
REQ-005 valA, valB, valC  input  64 each  register operands and constant.
REQ-006 alu_ctrl  output  2  ALU op: 00 add, 01 sub, 10 and, 11 xor.
REQ-007 alu_a, alu_b  output  64 each  ALU operands, result = alu_a OP alu_b.
REQ-008 alu_result  input  64; alu_ovf  input  1  ALU result and signed overflow, same cycle.
REQ-009 out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-010 out_icode  output  4; out_valA  output  64; out_valE  output  64; out_cnd  output  1; out_err  output  1.
REQ-011 cc  output  3  condition codes {ZF,SF,OF}.
REQ-012 halted  output  1  stage in HALTED state.

Function
REQ-013 ALU drive is combinational from icode/ifun/valA/valB/valC: OPq(6) a=valB b=valA ctrl=ifun[1:0]; RRMOVQ/CMOVxx(2) valA+0; IRMOVQ(3) valC+0; RMMOVQ(4)/MRMOVQ(5) valB+valC; CALL(8)/PUSHQ(A) valB-8; RET(9)/POPQ(B) valB+8; all others 0+0 add.
REQ-014 in_ready = (state==RUN) & (~out_valid | out_ready); transfer when in_valid & in_ready.
REQ-015 On transfer, output register loads out_valE=alu_result, out_icode, out_valA, out_cnd, out_err; out_valid=1 next cycle (latency 1, throughput 1/cycle).
REQ-016 out_valid clears when out_ready & ~transfer; registered outputs hold while out_valid & ~out_ready.
REQ-017 cc updates only on transfer of OPq with ifun<=3: ZF=(alu_result==0), SF=alu_result[63], OF=alu_ovf for add/sub, 0 for and/xor.
REQ-018 out_cnd for icode 2 or 7 evaluated on cc before the same-transfer update: ifun 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 ~ZF; 5 ~(SF^OF); 6 ~(SF^OF)&~ZF; 7-F 0. Other icodes: out_cnd=0.
REQ-019 out_err=1 for icode>B or OPq with ifun>3; errored instruction SHALL NOT update cc and SHALL enter HALTED.
REQ-020 State machine RUN->HALTED on transfer of HALT(0) or errored instruction; HALTED exits only by reset; final instruction still presented on output handshake.
REQ-021 Back-to-back OPq then CMOVxx/JXX: second instruction's cnd uses cc from first.

Reset
REQ-022 rst_n low asynchronously: state=RUN, out_valid=0, cc=3'b100, out_valE=0, out_valA=0, out_icode=1 (NOP), out_cnd=0, out_err=0.
REQ-023 Reset mid-transfer discards the pending instruction; no cc update.

Configuration
REQ-024 EXEC_OF_TRAP_EN defined: OPq add/sub with alu_ovf=1 sets out_err=1, still updates cc, enters HALTED. Undefined: overflow only reflected in cc.OF.

Structure
REQ-025 Shared package y86_pkg: icode constants, ifun/condition encodings, ALU ctrl encodings, cc bit indices, state enum.
REQ-026 One combinational sub-module cond_eval (ifun, cc -> cnd); ALU external.

Verification
REQ-027 addq valA=5 valB=7 -> alu_a=7 alu_b=5 ctrl=00, out_valE=12 next cycle, cc=000.
REQ-028 subq valA=3 valB=3 then jne -> valE=0, cc=100, jne out_cnd=0; je out_cnd=1.
REQ-029 addq valA=1 valB=0x7FFF_FFFF_FFFF_FFFF, alu_ovf=1 -> cc=011; with EXEC_OF_TRAP_EN out_err=1, halted=1.
REQ-030 pushq valB=0x100 -> ctrl=01, out_valE=0xF8, cc unchanged; out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
REQ-031 icode=0xC -> out_err=1, halted=1, in_ready=0 until rst_n pulse; after reset cc=100, out_valid=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the execute stage: instruction codes, condition
// functions, ALU controls, condition-code bit positions and the stage state.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] C_ALL = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // An instruction is illegal when its icode is past POPQ or it is an OPq
  // with an undefined function.
  function automatic logic is_illegal(input logic [3:0] icode, input logic [3:0] ifun);
    return (icode > I_POPQ) || ((icode == I_OPQ) && (ifun > 4'd3));
  endfunction

endpackage

// File: rtl/exec_stage_cond_eval.sv
// Branch / conditional-move condition evaluation from the {ZF,SF,OF} codes.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] cc,
  output logic       cnd
);

  logic w_zf;
  logic w_sf;
  logic w_of;

  assign w_zf = cc[CC_ZF];
  assign w_sf = cc[CC_SF];
  assign w_of = cc[CC_OF];

  // Decode the condition function against the flags
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_ALL:   cnd = 1'b1;
      C_LE:    cnd = (w_sf ^ w_of) | w_zf;
      C_L:     cnd = w_sf ^ w_of;
      C_E:     cnd = w_zf;
      C_NE:    cnd = ~w_zf;
      C_GE:    cnd = ~(w_sf ^ w_of);
      C_G:     cnd = ~(w_sf ^ w_of) & ~w_zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Y86 execute stage: drives an external ALU, keeps condition codes and halts on
// HALT or illegal instructions. Define EXEC_OF_TRAP_EN to trap signed overflow.
module exec_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic [1:0]  alu_ctrl,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_result,
  input  logic        alu_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_icode,
  output logic [63:0] out_valA,
  output logic [63:0] out_valE,
  output logic        out_cnd,
  output logic        out_err,
  output logic [2:0]  cc,
  output logic        halted
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_out_valid;
  logic [3:0]  r_out_icode;
  logic [63:0] r_out_valA;
  logic [63:0] r_out_valE;
  logic        r_out_cnd;
  logic        r_out_err;
  logic [2:0]  r_cc;

  logic        w_transfer;
  logic        w_err;
  logic        w_cond;
  logic        w_cnd;
  logic        w_cc_upd;
  logic        w_arith;
  logic [1:0]  w_ctrl;
  logic [63:0] w_a;
  logic [63:0] w_b;

  cond_eval u_cond_eval (
    .ifun (ifun),
    .cc   (r_cc),
    .cnd  (w_cond)
  );

  // ALU operand and operation selection
  always_comb begin
    w_ctrl = ALU_ADD;
    w_a    = 64'd0;
    w_b    = 64'd0;
    case (icode)
      I_OPQ:             begin w_a = valB; w_b = valA; w_ctrl = ifun[1:0]; end
      I_RRMOVQ:          begin w_a = valA; w_b = 64'd0; end
      I_IRMOVQ:          begin w_a = valC; w_b = 64'd0; end
      I_RMMOVQ, I_MRMOVQ: begin w_a = valB; w_b = valC; end
      I_CALL, I_PUSHQ:   begin w_a = valB; w_b = 64'd8; w_ctrl = ALU_SUB; end
      I_RET, I_POPQ:     begin w_a = valB; w_b = 64'd8; end
      default:           begin w_a = 64'd0; w_b = 64'd0; w_ctrl = ALU_ADD; end
    endcase
  end

  assign alu_ctrl = w_ctrl;
  assign alu_a    = w_a;
  assign alu_b    = w_b;

  assign in_ready   = (r_state == ST_RUN) & (~r_out_valid | out_ready);
  assign w_transfer = in_valid & in_ready;
  assign w_arith    = (icode == I_OPQ) && (ifun <= 4'd1);
  assign w_cc_upd   = w_transfer && (icode == I_OPQ) && (ifun <= 4'd3);
  assign w_cnd      = ((icode == I_RRMOVQ) || (icode == I_JXX)) ? w_cond : 1'b0;

`ifdef EXEC_OF_TRAP_EN
  assign w_err = is_illegal(icode, ifun) | (w_arith & alu_ovf);
`else
  assign w_err = is_illegal(icode, ifun);
`endif

  // Next state: any accepted HALT or errored instruction parks the stage
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_transfer && ((icode == I_HALT) || w_err)) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register: loads on transfer, drains on out_ready, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_icode <= I_NOP;
      r_out_valA  <= 64'd0;
      r_out_valE  <= 64'd0;
      r_out_cnd   <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_transfer) begin
      r_out_valid <= 1'b1;
      r_out_icode <= icode;
      r_out_valA  <= valA;
      r_out_valE  <= alu_result;
      r_out_cnd   <= w_cnd;
      r_out_err   <= w_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Condition codes; overflow only meaningful for add/sub
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= CC_RESET;
    end else if (w_cc_upd) begin
      r_cc[CC_ZF] <= (alu_result == 64'd0);
      r_cc[CC_SF] <= alu_result[63];
      r_cc[CC_OF] <= w_arith & alu_ovf;
    end
  end

  assign out_valid = r_out_valid;
  assign out_icode = r_out_icode;
  assign out_valA  = r_out_valA;
  assign out_valE  = r_out_valE;
  assign out_cnd   = r_out_cnd;
  assign out_err   = r_out_err;
  assign cc        = r_cc;
  assign halted    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_exec_stage.sv
// Directed testbench for exec_stage with a behavioural external ALU.
module tb_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [1:0]  alu_ctrl;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_result;
  logic        alu_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [63:0] out_valA;
  logic [63:0] out_valE;
  logic        out_cnd;
  logic        out_err;
  logic [2:0]  cc;
  logic        halted;

  int n_cmp;
  int n_mis;

  exec_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .ifun       (ifun),
    .valA       (valA),
    .valB       (valB),
    .valC       (valC),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_ovf    (alu_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_icode  (out_icode),
    .out_valA   (out_valA),
    .out_valE   (out_valE),
    .out_cnd    (out_cnd),
    .out_err    (out_err),
    .cc         (cc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU with signed-overflow detection for add and sub
  always_comb begin
    alu_ovf = 1'b0;
    case (alu_ctrl)
      2'b00: begin
        alu_result = alu_a + alu_b;
        alu_ovf = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      2'b01: begin
        alu_result = alu_a - alu_b;
        alu_ovf = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    icode    = ic;
    ifun     = fn;
    valA     = a;
    valB     = b;
    valC     = c;
    in_valid = 1'b1;
    #1;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    drive(ic, fn, a, b, c);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    icode     = 4'h1;
    ifun      = 4'h0;
    valA      = 64'd0;
    valB      = 64'd0;
    valC      = 64'd0;
    rst_n     = 1'b0;
    #12;
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_cc",        {61'd0, cc},        64'd4);
    check_val("rst_out_icode", {60'd0, out_icode}, 64'd1);
    check_val("rst_out_valE",  out_valE,           64'd0);
    check_val("rst_out_err",   {63'd0, out_err},   64'd0);
    check_val("rst_halted",    {63'd0, halted},    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // addq 5,7
    drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0);
    check_val("add_alu_a",    alu_a,              64'd7);
    check_val("add_alu_b",    alu_b,              64'd5);
    check_val("add_alu_ctrl", {62'd0, alu_ctrl},  64'd0);
    tick();
    in_valid = 1'b0;
    check_val("add_out_valid", {63'd0, out_valid}, 64'd1);
    check_val("add_valE",      out_valE,           64'd12);
    check_val("add_cc",        {61'd0, cc},        64'd0);
    check_val("add_icode",     {60'd0, out_icode}, 64'd6);

    // subq 3,3 then jne, je
    issue(4'h6, 4'h1, 64'd3, 64'd3, 64'd0);
    check_val("sub_valE", out_valE,    64'd0);
    check_val("sub_cc",   {61'd0, cc}, 64'd4);
    issue(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
    check_val("jne_cnd", {63'd0, out_cnd}, 64'd0);
    issue(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
    check_val("je_cnd",  {63'd0, out_cnd}, 64'd1);
    check_val("je_cc",   {61'd0, cc},      64'd4);

    // pushq with downstream stall
    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    check_val("push_ctrl",  {62'd0, alu_ctrl}, 64'd1);
    check_val("push_alu_b", alu_b,             64'd8);
    tick();
    check_val("push_valE", out_valE,    64'hF8);
    check_val("push_cc",   {61'd0, cc}, 64'd4);
    out_ready = 1'b0;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      check_val("stall_in_ready",  {63'd0, in_ready},  64'd0);
      tick();
      check_val("stall_valE",      out_valE,           64'hF8);
      check_val("stall_icode",     {60'd0, out_icode}, 64'hA);
      check_val("stall_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("drain_out_valid", {63'd0, out_valid}, 64'd0);

    // addq 2 + (-5), then cmovl / cmovg
    issue(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 64'd0);
    check_val("neg_valE", out_valE,    64'hFFFF_FFFF_FFFF_FFFD);
    check_val("neg_cc",   {61'd0, cc}, 64'd2);
    issue(4'h2, 4'h2, 64'd9, 64'd0, 64'd0);
    check_val("cmovl_cnd",  {63'd0, out_cnd}, 64'd1);
    check_val("cmovl_valE", out_valE,         64'd9);
    check_val("cmovl_valA", out_valA,         64'd9);
    issue(4'h2, 4'h6, 64'd9, 64'd0, 64'd0);
    check_val("cmovg_cnd",  {63'd0, out_cnd}, 64'd0);

    // xorq equal operands, then cmovle; irmovq
    issue(4'h6, 4'h3, 64'h55, 64'h55, 64'd0);
    check_val("xor_cc", {61'd0, cc}, 64'd4);
    issue(4'h2, 4'h1, 64'd1, 64'd0, 64'd0);
    check_val("cmovle_cnd", {63'd0, out_cnd}, 64'd1);
    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234);
    check_val("irmov_valE", out_valE, 64'h1234);

    // Signed overflow on addq
    issue(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    check_val("ovf_valE", out_valE,    64'h8000_0000_0000_0000);
    check_val("ovf_cc",   {61'd0, cc}, 64'd3);
`ifdef EXEC_OF_TRAP_EN
    check_val("ovf_err",    {63'd0, out_err}, 64'd1);
    check_val("ovf_halted", {63'd0, halted},  64'd1);
`else
    check_val("ovf_err",    {63'd0, out_err}, 64'd0);
    check_val("ovf_halted", {63'd0, halted},  64'd0);
`endif
    do_reset();

    // Reset asserted while an instruction is being transferred
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
    rst_n = 1'b0;
    tick();
    in_valid = 1'b0;
    check_val("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("midrst_cc",        {61'd0, cc},        64'd4);
    rst_n = 1'b1;
    tick();

    // HALT instruction
    issue(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
    check_val("halt_halted",   {63'd0, halted},    64'd1);
    check_val("halt_err",      {63'd0, out_err},   64'd0);
    check_val("halt_valid",    {63'd0, out_valid}, 64'd1);
    check_val("halt_icode",    {60'd0, out_icode}, 64'd0);
    check_val("halt_in_ready", {63'd0, in_ready},  64'd0);
    do_reset();

    // OPq with undefined function: error, cc untouched
    issue(4'h6, 4'h4, 64'd1, 64'd2, 64'd0);
    check_val("badfn_err",    {63'd0, out_err}, 64'd1);
    check_val("badfn_cc",     {61'd0, cc},      64'd4);
    check_val("badfn_halted", {63'd0, halted},  64'd1);
    do_reset();

    // Illegal icode 0xC
    issue(4'hC, 4'h0, 64'd0, 64'd0, 64'd0);
    check_val("ill_err",      {63'd0, out_err},  64'd1);
    check_val("ill_halted",   {63'd0, halted},   64'd1);
    check_val("ill_in_ready", {63'd0, in_ready}, 64'd0);
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
    tick();
    tick();
    in_valid = 1'b0;
    check_val("ill_hold_in_ready", {63'd0, in_ready},  64'd0);
    check_val("ill_hold_cc",       {61'd0, cc},        64'd4);
    check_val("ill_drained",       {63'd0, out_valid}, 64'd0);
    do_reset();
    check_val("post_rst_cc",     {61'd0, cc},        64'd4);
    check_val("post_rst_valid",  {63'd0, out_valid}, 64'd0);
    check_val("post_rst_halted", {63'd0, halted},    64'd0);
    check_val("post_rst_ready",  {63'd0, in_ready},  64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
